// File: rtl/cpu_mem_pkg.sv
// Shared memory-interface defaults and access-state constants, also used by the
// control unit's wait logic.
package cpu_mem_pkg;

  localparam int unsigned ADDR_W_DEF   = 9;
  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned DEPTH_DEF    = 512;
  localparam int unsigned READ_LAT_DEF = 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    WR,
    DONE
  } mem_state_t;

endpackage

// File: rtl/ram_sp_sync.sv
// Single-port synchronous RAM with a registered read port; the array has no reset.
module ram_sp_sync #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-side access sequencer between MAR/MDR and an internal single-port RAM:
// one read or write per request, with a done pulse and an err pulse for illegal requests.
module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned READ_LAT = READ_LAT_DEF
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] MDRdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              done,
  output logic              busy,
  output logic              err
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              err_d;
  logic              addr_bad;
  logic              we;
  logic [DATA_W-1:0] rdata;

  assign addr_bad = 32'(Address) >= DEPTH;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Read || Write) begin
          if ((Read && Write) || addr_bad) begin
            err_d = 1'b1;
          end else if (Read) begin
            addr_d  = Address;
            cnt_d   = 3'(READ_LAT);
            state_d = RD_WAIT;
          end else begin
            addr_d  = Address;
            wdata_d = MDRdata;
            state_d = WR;
          end
        end
      end
      RD_WAIT: begin
        if (cnt_q == 3'd0) state_d = RD_CAP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      RD_CAP:  state_d = DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err     <= 1'b0;
      Mdatain <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err     <= err_d;
      if (state_q == RD_CAP) Mdatain <= rdata;
    end
  end

  // clear gates the write strobe directly so an abort on the WR edge leaves RAM untouched.
  assign we   = (state_q == WR) && !clear;
  assign done = (state_q == DONE);
  assign busy = (state_q != IDLE);

  ram_sp_sync #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized traffic
// checked against a word-array model of the RAM and the expected Mdatain value.
module tb_mem_access_ctrl;

  localparam int unsigned LAT1 = 1;
  localparam int unsigned LAT2 = 3;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        Read = 1'b0, Write = 1'b0;
  logic [8:0]  Address = '0;
  logic [31:0] MDRdata = '0;
  logic [31:0] Mdatain;
  logic        done, busy, err;

  logic        r2 = 1'b0, w2 = 1'b0;
  logic [8:0]  a2 = '0;
  logic [31:0] d2 = '0;
  logic [31:0] q2;
  logic        done2, busy2, err2;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mm [512];
  logic [31:0] mq;
  int unsigned written [$];

  always #5 clock = ~clock;

  mem_access_ctrl #(.READ_LAT(LAT1)) u_dut (
    .clock(clock), .clear(clear), .Read(Read), .Write(Write), .Address(Address),
    .MDRdata(MDRdata), .Mdatain(Mdatain), .done(done), .busy(busy), .err(err)
  );

  mem_access_ctrl #(.READ_LAT(LAT2), .DEPTH(300)) u_dut2 (
    .clock(clock), .clear(clear), .Read(r2), .Write(w2), .Address(a2),
    .MDRdata(d2), .Mdatain(q2), .done(done2), .busy(busy2), .err(err2)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Edges until done rises (bounded); a timeout shows up as a wrong latency.
  task automatic wait_done(output int n);
    n = 0;
    do begin step(); n++; end while (!done && n < 20);
  endtask

  task automatic do_write(input int unsigned a, input logic [31:0] d);
    int n;
    Address = 9'(a); MDRdata = d; Write = 1'b1;
    step();
    Write = 1'b0; Address = 9'($urandom); MDRdata = $urandom;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL wr_start: busy=%b done=%b required busy=1 done=0", busy, done);
    end
    wait_done(n);
    n_cmp++;
    if (n != 1) begin n_bad++; $display("FAIL wr_latency: got %0d edges required 1", n); end
    n_cmp++;
    if (Mdatain !== mq) begin
      n_bad++; $display("FAIL wr_mdatain: got %h required %h", Mdatain, mq);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL wr_end: busy=%b done=%b required 0 0", busy, done);
    end
    mm[a] = d;
    written.push_back(a);
  endtask

  task automatic do_read(input int unsigned a);
    int n;
    Address = 9'(a); Read = 1'b1;
    step();
    Read = 1'b0; Address = 9'($urandom);
    wait_done(n);
    n_cmp++;
    if (n != int'(LAT1) + 2) begin
      n_bad++; $display("FAIL rd_latency: got %0d edges required %0d", n, LAT1 + 2);
    end
    mq = mm[a];
    n_cmp++;
    if (Mdatain !== mq) begin
      n_bad++; $display("FAIL rd_data addr %0d: got %h required %h", a, Mdatain, mq);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || Mdatain !== mq) begin
      n_bad++; $display("FAIL rd_end: busy=%b done=%b data=%h required 0 0 %h", busy, done, Mdatain, mq);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    step(); step();
    clear = 1'b0;
    mq = '0;
    n_cmp++;
    if ({busy, done, err} !== 3'b000 || Mdatain !== 32'h0) begin
      n_bad++; $display("FAIL reset: busy/done/err=%b data=%h required 000 0", {busy, done, err}, Mdatain);
    end
    n_cmp++;
    if ({busy2, done2, err2} !== 3'b000 || q2 !== 32'h0) begin
      n_bad++; $display("FAIL reset2: busy/done/err=%b data=%h required 000 0", {busy2, done2, err2}, q2);
    end
  endtask

  task automatic test_write_read();
    do_write(5, 32'h1234_5678);
    do_read(5);
  endtask

  task automatic test_illegal();
    do_write(7, 32'hDEAD_BEEF);
    Read = 1'b1; Write = 1'b1; Address = 9'd7; MDRdata = 32'h0;
    step();
    Read = 1'b0; Write = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL both_err: err=%b busy=%b done=%b required 1 0 0", err, busy, done);
    end
    step();
    n_cmp++;
    if (err !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL err_pulse: err=%b done=%b required 0 0", err, done);
    end
    do_read(7);
  endtask

  task automatic test_latch_ignore();
    int n;
    do_write(6, 32'hA5A5_0006);
    Read = 1'b1; Address = 9'd5;
    step();
    Read = 1'b0; Address = 9'd6; Write = 1'b1; MDRdata = 32'h0;
    step();
    Write = 1'b0; Read = 1'b1;
    step();
    Read = 1'b0;
    wait_done(n);
    n_cmp++;
    if (n != int'(LAT1)) begin
      n_bad++; $display("FAIL latch_latency: got %0d edges required %0d", n, LAT1);
    end
    mq = mm[5];
    n_cmp++;
    if (Mdatain !== mq) begin
      n_bad++; $display("FAIL addr_latch: got %h required %h", Mdatain, mq);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_bad++; $display("FAIL no_extra_done: done=%b busy=%b required 0 0", done, busy);
      end
    end
    do_read(6);
  endtask

  task automatic test_clear();
    logic [31:0] old;
    old = $urandom;
    do_write(20, old);
    Read = 1'b1; Address = 9'd20;
    step();
    Read = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    mq = '0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || Mdatain !== 32'h0) begin
      n_bad++; $display("FAIL clear_rd: busy=%b done=%b data=%h required 0 0 0", busy, done, Mdatain);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (done !== 1'b0 || Mdatain !== 32'h0) begin
        n_bad++; $display("FAIL clear_quiet: done=%b data=%h required 0 0", done, Mdatain);
      end
    end
    Write = 1'b1; Address = 9'd20; MDRdata = ~old;
    step();
    Write = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL clear_wr: busy=%b done=%b required 0 0", busy, done);
    end
    do_read(20);
  endtask

  task automatic test_back_to_back();
    int n;
    do_write(9, $urandom);
    Read = 1'b1; Address = 9'd5;
    step();
    wait_done(n);
    n_cmp++;
    if (n != int'(LAT1) + 2 || Mdatain !== mm[5]) begin
      n_bad++; $display("FAIL b2b_first: edges=%0d data=%h required %0d %h", n, Mdatain, LAT1 + 2, mm[5]);
    end
    Address = 9'd9;
    step();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_gap: busy=%b done=%b required 0 0", busy, done);
    end
    step();
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_restart: busy=%b required 1", busy); end
    Read = 1'b0;
    wait_done(n);
    mq = mm[9];
    n_cmp++;
    if (n != int'(LAT1) + 2 || Mdatain !== mq) begin
      n_bad++; $display("FAIL b2b_second: edges=%0d data=%h required %0d %h", n, Mdatain, LAT1 + 2, mq);
    end
    step();
  endtask

  task automatic test_random();
    int unsigned op, a;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: do_write($urandom_range(0, 511), $urandom);
        1: begin
          a = written[$urandom_range(0, written.size() - 1)];
          do_read(a);
        end
        2: begin
          Read = 1'b1; Write = 1'b1; Address = 9'($urandom); MDRdata = $urandom;
          step();
          Read = 1'b0; Write = 1'b0;
          n_cmp++;
          if (err !== 1'b1 || busy !== 1'b0 || Mdatain !== mq) begin
            n_bad++; $display("FAIL rnd_err: err=%b busy=%b data=%h required 1 0 %h", err, busy, Mdatain, mq);
          end
          step();
        end
        default: begin
          Address = 9'($urandom); MDRdata = $urandom;
          step();
          n_cmp++;
          if ({busy, done, err} !== 3'b000 || Mdatain !== mq) begin
            n_bad++; $display("FAIL rnd_idle: b/d/e=%b data=%h required 000 %h", {busy, done, err}, Mdatain, mq);
          end
        end
      endcase
    end
  endtask

  task automatic test_params();
    int n;
    logic [31:0] d10, d299;
    d10 = $urandom; d299 = $urandom;
    for (int k = 0; k < 2; k++) begin
      w2 = 1'b1; a2 = (k == 0) ? 9'd10 : 9'd299; d2 = (k == 0) ? d10 : d299;
      step();
      w2 = 1'b0;
      n = 0;
      do begin step(); n++; end while (!done2 && n < 20);
      n_cmp++;
      if (n != 1) begin n_bad++; $display("FAIL p_wr_latency: got %0d required 1", n); end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      r2 = 1'b1; a2 = (k == 0) ? 9'd10 : 9'd299;
      step();
      r2 = 1'b0;
      n = 0;
      do begin step(); n++; end while (!done2 && n < 20);
      n_cmp++;
      if (n != int'(LAT2) + 2 || q2 !== ((k == 0) ? d10 : d299)) begin
        n_bad++; $display("FAIL p_rd: edges=%0d data=%h required %0d %h", n, q2, LAT2 + 2, (k == 0) ? d10 : d299);
      end
      step();
    end
    for (int k = 0; k < 2; k++) begin
      r2 = 1'b1; a2 = (k == 0) ? 9'd400 : 9'd300;
      step();
      r2 = 1'b0;
      n_cmp++;
      if (err2 !== 1'b1 || busy2 !== 1'b0) begin
        n_bad++; $display("FAIL p_range addr %0d: err=%b busy=%b required 1 0", a2, err2, busy2);
      end
      step();
      n_cmp++;
      if (err2 !== 1'b0 || done2 !== 1'b0 || busy2 !== 1'b0 || q2 !== d299) begin
        n_bad++; $display("FAIL p_range_after: err=%b done=%b busy=%b data=%h required 0 0 0 %h", err2, done2, busy2, q2, d299);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_illegal();
    test_latch_ignore();
    test_clear();
    test_back_to_back();
    test_random();
    test_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
